loom_switch_buffered: RTL and testbench

//  Parametrised NUM_IN x NUM_OUT crossbar switch with a valid/ready handshake and a FIFO on every output.

---
 rtl/loom_switch_pkg.sv | 22 ++
 rtl/loom_sync_fifo.sv | 71 +++++++
 rtl/loom_switch_buffered.sv | 159 +++++++++++++++
 tb/tb_loom_switch_buffered.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loom_switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loom_switch_pkg
//  Brief    : Shared types, error codes and route-table indexing helper for
//             the buffered crossbar switch.
//  Revision : 1.0  initial release
// ============================================================================
package loom_switch_pkg;

    typedef logic [15:0] error_code_t;

    localparam error_code_t ERR_NONE      = 16'd0;
    localparam error_code_t ERR_MULTI_SRC = 16'd1;
    localparam error_code_t ERR_UNROUTED  = 16'd2;

    // Bit position of the (output o, input i) entry in the route table.
    function automatic int route_idx(input int o, input int i, input int num_in);
        return o * num_in + i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/loom_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : loom_sync_fifo
//  Brief    : Single-clock FIFO, power-of-two depth, head entry exposed
//             directly (first-word fall-through). A full FIFO ignores a push
//             even if it pops in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module loom_sync_fifo
    import loom_switch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage array; contents need no reset because the count gates validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count spans 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/loom_switch_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : loom_switch_buffered
//  Brief    : NUM_IN x NUM_OUT crossbar with static route table, broadcast,
//             a FIFO per output and a sticky configuration-error latch.
//             Optional per-output pop counters when LOOM_SWITCH_PERF_CNT_EN
//             is defined.
//  Revision : 1.0  initial release
// ============================================================================
module loom_switch_buffered
    import loom_switch_pkg::*;
#(
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             in_valid,
    output logic [NUM_IN-1:0]             in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_IN*NUM_OUT-1:0]     cfg_route_table,
    output logic                          error_valid,
    output logic [15:0]                   error_code
`ifdef LOOM_SWITCH_PERF_CNT_EN
    ,
    output logic [NUM_OUT*CNT_WIDTH-1:0]  perf_xfer_cnt
`endif
);

    logic [NUM_OUT-1:0]                 w_col_any;
    logic [NUM_OUT-1:0]                 w_conflict;
    logic [NUM_OUT-1:0]                 w_legal;
    logic [NUM_IN-1:0][NUM_OUT-1:0]     w_target;
    logic [NUM_IN-1:0]                  w_has_target;
    logic [NUM_OUT-1:0]                 w_push;
    logic [NUM_OUT-1:0][DATA_WIDTH-1:0] w_push_data;
    logic [NUM_OUT-1:0]                 w_full;
    logic [NUM_OUT-1:0]                 w_empty;
    logic [NUM_OUT-1:0]                 w_pop;
    logic                               w_err_multi;
    logic                               w_err_unrouted;
    logic                               r_error_valid;
    error_code_t                        r_error_code;

    // Column decode: an output is legal with exactly one source, in conflict with two or more.
    always_comb begin
        w_col_any  = '0;
        w_conflict = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (cfg_route_table[route_idx(o, i, NUM_IN)]) begin
                    if (w_col_any[o]) begin
                        w_conflict[o] = 1'b1;
                    end
                    w_col_any[o] = 1'b1;
                end
            end
        end
        w_legal = w_col_any & ~w_conflict;
    end

    // Ready join: an input is ready only if it has targets and none of them is full.
    always_comb begin
        w_target     = '0;
        w_has_target = '0;
        in_ready     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                w_target[i][o] = w_legal[o] & cfg_route_table[route_idx(o, i, NUM_IN)];
            end
            w_has_target[i] = |w_target[i];
            in_ready[i]     = w_has_target[i] && ((w_target[i] & w_full) == '0);
        end
    end

    // Push steering: a legal output has a single source, so the last match is the only match.
    always_comb begin
        w_push      = '0;
        w_push_data = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_target[i][o]) begin
                    w_push[o]      = in_valid[i] & in_ready[i];
                    w_push_data[o] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;

    generate
        for (genvar o = 0; o < NUM_OUT; o++) begin : g_out_fifo
            loom_sync_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[o]),
                .i_data  (w_push_data[o]),
                .i_pop   (w_pop[o]),
                .o_full  (w_full[o]),
                .o_empty (w_empty[o]),
                .o_head  (out_data[o*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    assign w_err_multi    = |w_conflict;
    assign w_err_unrouted = |(in_valid & ~w_has_target);

    // Sticky error latch: first error wins, lower code wins within a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error_valid <= 1'b0;
            r_error_code  <= ERR_NONE;
        end else if (!r_error_valid) begin
            if (w_err_multi) begin
                r_error_valid <= 1'b1;
                r_error_code  <= ERR_MULTI_SRC;
            end else if (w_err_unrouted) begin
                r_error_valid <= 1'b1;
                r_error_code  <= ERR_UNROUTED;
            end
        end
    end

    assign error_valid = r_error_valid;
    assign error_code  = r_error_code;

`ifdef LOOM_SWITCH_PERF_CNT_EN
    generate
        for (genvar o = 0; o < NUM_OUT; o++) begin : g_perf_cnt
            logic [CNT_WIDTH-1:0] r_cnt;

            // Count pops, saturating at all-ones.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_pop[o] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign perf_xfer_cnt[o*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_loom_switch_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loom_switch_buffered
//  Brief    : Directed bench for the 2x2 buffered switch. Expected output
//             words are queued per output when stimulus is issued; a monitor
//             pops and compares on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_loom_switch_buffered;

    localparam int c_DW = 32;

    logic        clk;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [63:0] in_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [63:0] out_data;
    logic [3:0]  cfg_route_table;
    logic        error_valid;
    logic [15:0] error_code;
`ifdef LOOM_SWITCH_PERF_CNT_EN
    logic [63:0] perf_xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [c_DW-1:0] exp_q0[$];
    logic [c_DW-1:0] exp_q1[$];

    loom_switch_buffered #(
        .NUM_IN     (2),
        .NUM_OUT    (2),
        .DATA_WIDTH (c_DW),
        .DEPTH      (2),
        .CNT_WIDTH  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .cfg_route_table (cfg_route_table),
        .error_valid     (error_valid),
        .error_code      (error_code)
`ifdef LOOM_SWITCH_PERF_CNT_EN
        ,
        .perf_xfer_cnt   (perf_xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Move to the next cycle, inputs change shortly after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every output handshake must match the head of that output's queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid[0] && out_ready[0]) begin
                if (exp_q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out0_unexpected actual=%0h required=none", out_data[31:0]);
                end else begin
                    check("out0_data", {32'h0, out_data[31:0]}, {32'h0, exp_q0.pop_front()});
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                if (exp_q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out1_unexpected actual=%0h required=none", out_data[63:32]);
                end else begin
                    check("out1_data", {32'h0, out_data[63:32]}, {32'h0, exp_q1.pop_front()});
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        in_valid        = 2'b00;
        in_data         = '0;
        out_ready       = 2'b00;
        cfg_route_table = 4'b0000;

        // 1. reset state
        repeat (3) step();
        sample();
        check("rst_out_valid", {62'h0, out_valid}, 64'h0);
        check("rst_in_ready", {62'h0, in_ready}, 64'h0);
        check("rst_err_valid", {63'h0, error_valid}, 64'h0);
        check("rst_err_code", {48'h0, error_code}, 64'h0);
        step();
        rst = 1'b0;

        // 2. straight routing, one word per input
        cfg_route_table = 4'b1001;
        out_ready       = 2'b11;
        in_valid        = 2'b11;
        in_data         = {32'hB1B1, 32'hA0A0};
        exp_q0.push_back(32'hA0A0);
        exp_q1.push_back(32'hB1B1);
        sample();
        check("t2_in_ready", {62'h0, in_ready}, 64'h3);
        step();
        in_valid = 2'b00;
        sample();
        check("t2_latency_valid", {62'h0, out_valid}, 64'h3);
        step();
        sample();
        check("t2_drained", {62'h0, out_valid}, 64'h0);
`ifdef LOOM_SWITCH_PERF_CNT_EN
        check("t2_perf0", {32'h0, perf_xfer_cnt[31:0]}, 64'h1);
        check("t2_perf1", {32'h0, perf_xfer_cnt[63:32]}, 64'h1);
`endif

        // 3. backpressure on out0
        step();
        out_ready      = 2'b10;
        in_valid       = 2'b01;
        in_data[31:0]  = 32'h1;
        exp_q0.push_back(32'h1);
        exp_q0.push_back(32'h2);
        exp_q0.push_back(32'h3);
        sample();
        check("t3_acc1", {63'h0, in_ready[0]}, 64'h1);
        step();
        in_data[31:0] = 32'h2;
        sample();
        check("t3_acc2", {63'h0, in_ready[0]}, 64'h1);
        step();
        in_data[31:0] = 32'h3;
        sample();
        check("t3_full_a", {63'h0, in_ready[0]}, 64'h0);
        check("t3_out_valid", {63'h0, out_valid[0]}, 64'h1);
        step();
        sample();
        check("t3_full_b", {63'h0, in_ready[0]}, 64'h0);
        step();
        out_ready = 2'b11;
        sample();
        check("t3_full_pop", {63'h0, in_ready[0]}, 64'h0);
        step();
        sample();
        check("t3_acc3", {63'h0, in_ready[0]}, 64'h1);
        step();
        in_valid = 2'b00;
        sample();
        step();
        sample();
        check("t3_drained", {62'h0, out_valid}, 64'h0);

        // 4. broadcast in0 -> out0,out1 with out1 stalled
        step();
        cfg_route_table = 4'b0101;
        out_ready       = 2'b01;
        in_valid        = 2'b01;
        in_data[31:0]   = 32'h51;
        exp_q0.push_back(32'h51);
        exp_q0.push_back(32'h52);
        exp_q1.push_back(32'h51);
        exp_q1.push_back(32'h52);
        sample();
        check("t4_acc1", {63'h0, in_ready[0]}, 64'h1);
        step();
        in_data[31:0] = 32'h52;
        sample();
        check("t4_acc2", {63'h0, in_ready[0]}, 64'h1);
        for (int k = 3; k <= 5; k++) begin
            step();
            in_data[31:0] = 32'h50 + k;
            sample();
            check("t4_stall", {63'h0, in_ready[0]}, 64'h0);
        end
        check("t4_no_dup", {63'h0, out_valid[0]}, 64'h0);
        check("t4_out1_held", {63'h0, out_valid[1]}, 64'h1);
        step();
        in_valid  = 2'b00;
        out_ready = 2'b11;
        repeat (3) step();
        sample();
        check("t4_drained", {62'h0, out_valid}, 64'h0);

        // 5. transient multi-source error is sticky
        step();
        cfg_route_table = 4'b0011;
        sample();
        check("t5_conflict_ready", {62'h0, in_ready}, 64'h0);
        check("t5_not_yet", {63'h0, error_valid}, 64'h0);
        step();
        cfg_route_table = 4'b1001;
        sample();
        check("t5_err_valid", {63'h0, error_valid}, 64'h1);
        check("t5_err_code", {48'h0, error_code}, 64'h1);
        repeat (3) step();
        sample();
        check("t5_err_hold", {48'h0, error_code}, 64'h1);
        step();
        rst = 1'b1;
        repeat (2) step();
        sample();
        check("t5_err_cleared", {63'h0, error_valid}, 64'h0);
        step();
        rst = 1'b0;

        // 6. unrouted input raises code 2
        cfg_route_table = 4'b0001;
        in_valid        = 2'b10;
        sample();
        check("t6_in1_ready", {63'h0, in_ready[1]}, 64'h0);
        step();
        in_valid = 2'b00;
        sample();
        check("t6_err_valid", {63'h0, error_valid}, 64'h1);
        check("t6_err_code", {48'h0, error_code}, 64'h2);

        step();
        check("q0_empty", 64'(exp_q0.size()), 64'h0);
        check("q1_empty", 64'(exp_q1.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
